// File: rtl/dbg_probe_capture_pkg.sv
// Shared debug definitions: capture FSM state encodings and the probe_bus
// channel map used by the CPU top level when packing debug nets.
package dbg_probe_capture_pkg;

    typedef enum logic [1:0] {
        DBG_LIVE    = 2'b00,
        DBG_ARMED   = 2'b01,
        DBG_POSTCAP = 2'b10,
        DBG_FROZEN  = 2'b11
    } dbg_state_e;

    // Pipeline group
    localparam int CH_PIPE_PC      = 0;
    localparam int CH_PIPE_INSTR   = 1;
    localparam int CH_PIPE_STALL   = 2;
    localparam int CH_PIPE_FLUSH   = 3;
    // Memory group
    localparam int CH_MEM_ADDR_LO  = 8;
    localparam int CH_MEM_ADDR_HI  = 9;
    localparam int CH_MEM_WDATA    = 10;
    localparam int CH_MEM_RDATA    = 11;
    // Flash group
    localparam int CH_FLASH_ADDR   = 16;
    localparam int CH_FLASH_DATA   = 17;
    localparam int CH_FLASH_STATUS = 18;
    // Register file group: one channel per architectural register
    localparam int CH_REGFILE_BASE = 32;
    localparam int CH_REGFILE_NUM  = 32;

endpackage

// File: rtl/dbg_hist_ram.sv
// Capture history storage: DEPTH x W, one synchronous write port and one
// registered read port.
module dbg_hist_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dbg_probe_capture.sv
// Debug probe selector with a triggerable capture ring buffer; drives the
// board LEDs with either the live channel or a browsed frozen history entry.
module dbg_probe_capture
    import dbg_probe_capture_pkg::*;
#(
    parameter int W     = 16,
    parameter int NCH   = 64,
    parameter int SELW  = 8,
    parameter int DEPTH = 8,
    parameter int POST  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*W-1:0]         probe_bus,
    input  logic [SELW-1:0]          sel,
    input  logic                     sample_en,
    input  logic                     arm,
    input  logic [W-1:0]             trig_value,
    input  logic [W-1:0]             trig_mask,
    input  logic [$clog2(DEPTH)-1:0] hist_idx,
    output logic [W-1:0]             led_data,
    output logic [1:0]               state,
    output logic                     triggered,
    output logic [$clog2(DEPTH):0]   hist_count
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int CNTW = IDXW + 1;

    dbg_state_e      state_q, state_d;
    logic [CNTW-1:0] post_q, post_d;
    logic [CNTW-1:0] count_q;
    logic [IDXW-1:0] wptr_q;
    logic [IDXW-1:0] rd_addr;
    logic [W-1:0]    selected;
    logic [W-1:0]    live_q;
    logic [W-1:0]    rd_data;
    logic            show_hist_q;
    logic            hist_ok_q;
    logic            write_en;
    logic            trig_hit;

    // Out-of-range selects read as zero rather than aliasing onto a channel.
    always_comb begin
        selected = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(sel) == k) begin
                selected = probe_bus[k*W +: W];
            end
        end
    end

    assign trig_hit = (((selected ^ trig_value) & trig_mask) == '0);
    assign write_en = sample_en && !arm && (state_q != DBG_FROZEN);
    assign rd_addr  = wptr_q - IDXW'(1) - hist_idx;

    dbg_hist_ram #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_hist_ram (
        .clk     (clk),
        .wr_en   (write_en),
        .wr_addr (wptr_q),
        .wr_data (selected),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DBG_LIVE;
            post_q  <= '0;
        end else begin
            state_q <= state_d;
            post_q  <= post_d;
        end
    end

    always_comb begin
        state_d = state_q;
        post_d  = post_q;
        if (arm) begin
            state_d = DBG_ARMED;
            post_d  = '0;
        end else begin
            case (state_q)
                DBG_ARMED: begin
                    if (sample_en && trig_hit) begin
                        if (POST == 0) begin
                            state_d = DBG_FROZEN;
                        end else begin
                            state_d = DBG_POSTCAP;
                            post_d  = CNTW'(POST);
                        end
                    end
                end
                DBG_POSTCAP: begin
                    if (sample_en) begin
                        post_d = post_q - 1'b1;
                        if (post_q == CNTW'(1)) begin
                            state_d = DBG_FROZEN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The display select and range flag are registered alongside the RAM read
    // so a frozen entry and its validity line up on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            count_q     <= '0;
            live_q      <= '0;
            show_hist_q <= 1'b0;
            hist_ok_q   <= 1'b0;
        end else begin
            live_q      <= selected;
            show_hist_q <= (state_q == DBG_FROZEN);
            hist_ok_q   <= ({1'b0, hist_idx} < count_q);
            if (arm) begin
                wptr_q  <= '0;
                count_q <= '0;
            end else if (write_en) begin
                wptr_q <= wptr_q + 1'b1;
                if (count_q != CNTW'(DEPTH)) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign led_data   = show_hist_q ? (hist_ok_q ? rd_data : '0) : live_q;
    assign state      = state_q;
    assign triggered  = (state_q == DBG_POSTCAP) || (state_q == DBG_FROZEN);
    assign hist_count = count_q;

endmodule

// File: tb/tb_dbg_probe_capture.sv
// Directed bench for dbg_probe_capture: live select, trigger/freeze, wrap,
// masked compare, POST=0 variant, and re-arm/reset priority.
module tb_dbg_probe_capture;

    localparam int W     = 16;
    localparam int NCH   = 4;
    localparam int SELW  = 8;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    ch0, ch1, ch2, ch3;
    logic [NCH*W-1:0] probe_bus;
    logic [SELW-1:0] sel;
    logic            sample_en;
    logic            arm;
    logic [W-1:0]    trig_value;
    logic [W-1:0]    trig_mask;
    logic [2:0]      hist_idx;

    logic [W-1:0]    led_data,   led_data_p0;
    logic [1:0]      state,      state_p0;
    logic            triggered,  triggered_p0;
    logic [3:0]      hist_count, hist_count_p0;

    int checks = 0;
    int errors = 0;

    assign probe_bus = {ch3, ch2, ch1, ch0};

    always #5 clk = ~clk;

    dbg_probe_capture #(
        .W(W), .NCH(NCH), .SELW(SELW), .DEPTH(DEPTH), .POST(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .probe_bus  (probe_bus),
        .sel        (sel),
        .sample_en  (sample_en),
        .arm        (arm),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .hist_idx   (hist_idx),
        .led_data   (led_data),
        .state      (state),
        .triggered  (triggered),
        .hist_count (hist_count)
    );

    dbg_probe_capture #(
        .W(W), .NCH(NCH), .SELW(SELW), .DEPTH(DEPTH), .POST(0)
    ) dut_p0 (
        .clk        (clk),
        .rst        (rst),
        .probe_bus  (probe_bus),
        .sel        (sel),
        .sample_en  (sample_en),
        .arm        (arm),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .hist_idx   (hist_idx),
        .led_data   (led_data_p0),
        .state      (state_p0),
        .triggered  (triggered_p0),
        .hist_count (hist_count_p0)
    );

    // Drive one cycle of inputs, then let the edge land and settle.
    task automatic applyStimulus(input logic [SELW-1:0] s, input logic [W-1:0] c0,
                                 input logic se, input logic a, input logic r);
        sel       = s;
        ch0       = c0;
        sample_en = se;
        arm       = a;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; sample_en = 1'b0; sel = '0; hist_idx = '0;
        ch0 = '0; ch1 = 16'h1111; ch2 = '0; ch3 = 16'h3333;
        trig_value = '0; trig_mask = '0;

        // Reset and live select
        applyStimulus(8'd0, 16'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        checkOutput("rst_led", led_data, 0);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_count", hist_count, 0);
        checkOutput("rst_trig", triggered, 0);
        ch2 = 16'hBEEF;
        applyStimulus(8'd2, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("live_sel2", led_data, 16'hBEEF);
        applyStimulus(8'd5, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("live_sel5", led_data, 0);
        applyStimulus(8'd3, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("live_sel3", led_data, 16'h3333);

        // Trigger on 3, capture 4 and 5, ignore 6
        trig_value = 16'd3; trig_mask = 16'hFFFF;
        applyStimulus(8'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("arm_state", state, 1);
        checkOutput("arm_count", hist_count, 0);
        applyStimulus(8'd0, 16'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'd0, 16'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("pretrig_state", state, 1);
        checkOutput("pretrig_count", hist_count, 2);
        checkOutput("pretrig_led", led_data, 2);
        applyStimulus(8'd0, 16'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("trig_state", state, 2);
        checkOutput("trig_flag", triggered, 1);
        applyStimulus(8'd0, 16'd4, 1'b1, 1'b0, 1'b0);
        checkOutput("post1_state", state, 2);
        applyStimulus(8'd0, 16'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("frozen_state", state, 3);
        applyStimulus(8'd0, 16'd6, 1'b1, 1'b0, 1'b0);
        checkOutput("frozen_count", hist_count, 5);
        hist_idx = 3'd0;
        applyStimulus(8'd0, 16'd6, 1'b0, 1'b0, 1'b0);
        checkOutput("hist_idx0", led_data, 5);
        hist_idx = 3'd4;
        applyStimulus(8'd0, 16'd6, 1'b0, 1'b0, 1'b0);
        checkOutput("hist_idx4", led_data, 1);
        hist_idx = 3'd5;
        applyStimulus(8'd0, 16'd6, 1'b0, 1'b0, 1'b0);
        checkOutput("hist_idx5", led_data, 0);

        // Wrap in LIVE, then first-sample trigger after a clearing arm
        applyStimulus(8'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst2_state", state, 0);
        for (int v = 10; v < 20; v++) begin
            applyStimulus(8'd0, 16'(v), 1'b1, 1'b0, 1'b0);
        end
        checkOutput("wrap_count", hist_count, 8);
        checkOutput("wrap_state", state, 0);
        checkOutput("wrap_led", led_data, 19);
        trig_mask = 16'h0000;
        applyStimulus(8'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("rearm_count", hist_count, 0);
        applyStimulus(8'd0, 16'd20, 1'b1, 1'b0, 1'b0);
        checkOutput("m0_state", state, 2);
        checkOutput("p0_state", state_p0, 3);
        applyStimulus(8'd0, 16'd21, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'd0, 16'd22, 1'b1, 1'b0, 1'b0);
        checkOutput("m0_frozen", state, 3);
        checkOutput("m0_count", hist_count, 3);
        checkOutput("p0_count", hist_count_p0, 1);
        hist_idx = 3'd0;
        applyStimulus(8'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("m0_idx0", led_data, 22);
        checkOutput("p0_idx0", led_data_p0, 20);
        hist_idx = 3'd1;
        applyStimulus(8'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("m0_idx1", led_data, 21);
        checkOutput("p0_idx1", led_data_p0, 0);
        hist_idx = 3'd2;
        applyStimulus(8'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("m0_idx2", led_data, 20);

        // Masked compare on the low byte
        trig_mask = 16'h00FF; trig_value = 16'h0034;
        applyStimulus(8'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'd0, 16'h1235, 1'b1, 1'b0, 1'b0);
        checkOutput("mask_miss", state, 1);
        applyStimulus(8'd0, 16'h1234, 1'b1, 1'b0, 1'b0);
        checkOutput("mask_hit1", state, 2);
        applyStimulus(8'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'd0, 16'hAB34, 1'b1, 1'b0, 1'b0);
        checkOutput("mask_hit2", state, 2);
        checkOutput("mask_count", hist_count, 1);

        // Re-arm mid-POSTCAP, arm beats sample, rst beats everything
        applyStimulus(8'd0, 16'h0001, 1'b1, 1'b0, 1'b0);
        checkOutput("postcap_count", hist_count, 2);
        applyStimulus(8'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("rearm_post_state", state, 1);
        checkOutput("rearm_post_count", hist_count, 0);
        applyStimulus(8'd0, 16'hAB34, 1'b1, 1'b1, 1'b0);
        checkOutput("arm_sample_state", state, 1);
        checkOutput("arm_sample_count", hist_count, 0);
        applyStimulus(8'd0, 16'hAB34, 1'b1, 1'b1, 1'b1);
        checkOutput("rst_prio_state", state, 0);
        checkOutput("rst_prio_count", hist_count, 0);
        checkOutput("rst_prio_trig", triggered, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
